// File: rtl/dot_int_pkg.sv
// Shared helpers for the integer dot-product family: beat and width arithmetic
// plus a saturating signed resize reused by the MX dot blocks.
package dot_int_pkg;

    function automatic int beats(input int k, input int lanes);
        return k / lanes;
    endfunction

    function automatic int acc_width_of(input int prd_width, input int k);
        return prd_width + $clog2(k);
    endfunction

    // A single-beat vector still gets a 1-bit counter so ports never go zero-width.
    function automatic int cnt_width_of(input int k, input int lanes);
        return (k / lanes > 1) ? $clog2(k / lanes) : 1;
    endfunction

    function automatic logic signed [63:0] sat_resize(input logic signed [63:0] val,
                                                      input int out_width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = ~hi;
        if (out_width >= 64) return val;
        if (val > hi) return hi;
        if (val < lo) return lo;
        return val;
    endfunction

endpackage

// File: rtl/vec_mul_int.sv
// Element-wise signed multiply of two packed vectors, full-width products.
module vec_mul_int #(
    parameter int bit_width = 8,
    parameter int length    = 8,
    parameter int prd_width = 2 * bit_width
) (
    input  logic [length-1:0][bit_width-1:0] i_a,
    input  logic [length-1:0][bit_width-1:0] i_b,
    output logic [length-1:0][prd_width-1:0] o_prd
);

    always_comb begin
        for (int i = 0; i < length; i++) begin
            o_prd[i] = prd_width'(signed'(i_a[i])) * prd_width'(signed'(i_b[i]));
        end
    end

endmodule

// File: rtl/vec_sum_int.sv
// Signed reduction of a packed vector; result width grows by log2(length).
module vec_sum_int #(
    parameter int bit_width = 16,
    parameter int length    = 8,
    parameter int sum_width = bit_width + $clog2(length)
) (
    input  logic [length-1:0][bit_width-1:0] i_vec,
    output logic [sum_width-1:0]             o_sum
);

    logic [sum_width-1:0] total;

    always_comb begin
        total = '0;
        for (int i = 0; i < length; i++) begin
            total = total + sum_width'(signed'(i_vec[i]));
        end
        o_sum = total;
    end

endmodule

// File: rtl/dot_int_seq.sv
// Streaming two-stage signed dot product, `lanes` element pairs per beat.
// Define DOT_INT_SEQ_SAT_EN to saturate (instead of wrap) when out_width < acc_width.
module dot_int_seq
    import dot_int_pkg::*;
#(
    parameter int bit_width = 8,
    parameter int k         = 32,
    parameter int lanes     = 8,
    parameter int prd_width = 2 * bit_width,
    parameter int acc_width = acc_width_of(prd_width, k),
    parameter int out_width = acc_width
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [lanes-1:0][bit_width-1:0] i_vec_a,
    input  logic [lanes-1:0][bit_width-1:0] i_vec_b,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [out_width-1:0]            o_dp
);

    localparam int n_beats   = beats(k, lanes);
    localparam int cnt_width = cnt_width_of(k, lanes);
    localparam int sum_width = prd_width + $clog2(lanes);
    localparam logic [cnt_width-1:0] last_cnt = cnt_width'(n_beats - 1);

    logic [cnt_width-1:0]            cnt_q, cnt_d;
    logic [lanes-1:0][prd_width-1:0] prd, p1_prd_q, p1_prd_d;
    logic                            p1_vld_q, p1_vld_d;
    logic                            p1_last_q, p1_last_d;
    logic [acc_width-1:0]            acc_q, acc_d;
    logic                            o_valid_q, o_valid_d;
    logic [out_width-1:0]            dp_q, dp_d;
    logic [sum_width-1:0]            lane_sum;
    logic [acc_width-1:0]            s;
    logic [out_width-1:0]            dp_fmt;
    logic                            stall, accept, last;

    // A pending result the consumer has not taken freezes the whole pipe.
    assign stall   = o_valid_q & ~i_ready;
    assign accept  = i_valid & ~stall;
    assign last    = (cnt_q == last_cnt);
    assign o_ready = ~stall;
    assign o_valid = o_valid_q;
    assign o_dp    = dp_q;

    vec_mul_int #(
        .bit_width (bit_width),
        .length    (lanes),
        .prd_width (prd_width)
    ) u_mul (
        .i_a   (i_vec_a),
        .i_b   (i_vec_b),
        .o_prd (prd)
    );

    vec_sum_int #(
        .bit_width (prd_width),
        .length    (lanes)
    ) u_sum (
        .i_vec (p1_prd_q),
        .o_sum (lane_sum)
    );

    assign s = acc_q + acc_width'(signed'(lane_sum));

`ifdef DOT_INT_SEQ_SAT_EN
    assign dp_fmt = out_width'(sat_resize(64'(signed'(s)), out_width));
`else
    assign dp_fmt = out_width'(s);
`endif

    always_comb begin
        cnt_d     = cnt_q;
        p1_prd_d  = p1_prd_q;
        p1_vld_d  = p1_vld_q;
        p1_last_d = p1_last_q;
        acc_d     = acc_q;
        o_valid_d = o_valid_q;
        dp_d      = dp_q;
        if (!stall) begin
            p1_prd_d  = prd;
            p1_vld_d  = accept;
            p1_last_d = accept & last;
            if (accept) begin
                cnt_d = last ? '0 : cnt_q + cnt_width'(1);
            end
            // Not stalled means any held result is being taken this cycle.
            o_valid_d = 1'b0;
            if (p1_vld_q) begin
                if (p1_last_q) begin
                    acc_d     = '0;
                    o_valid_d = 1'b1;
                    dp_d      = dp_fmt;
                end else begin
                    acc_d = s;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            p1_prd_q  <= '0;
            p1_vld_q  <= 1'b0;
            p1_last_q <= 1'b0;
            acc_q     <= '0;
            o_valid_q <= 1'b0;
            dp_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            p1_prd_q  <= p1_prd_d;
            p1_vld_q  <= p1_vld_d;
            p1_last_q <= p1_last_d;
            acc_q     <= acc_d;
            o_valid_q <= o_valid_d;
            dp_q      <= dp_d;
        end
    end

endmodule

// File: tb/tb_dot_int_seq.sv
// Bench for dot_int_seq: a full-width and a 16-bit-output instance share stimulus
// and are scored against an arithmetic dot-product model.
module tb_dot_int_seq;

    localparam int bit_width    = 8;
    localparam int k            = 32;
    localparam int lanes        = 8;
    localparam int n_beats      = 4;
    localparam int acc_width    = 21;
    localparam int narrow_width = 16;

`ifdef DOT_INT_SEQ_SAT_EN
    localparam int narrow_127 = 32767;
`else
    localparam int narrow_127 = -8160;
`endif

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_valid = 1'b0;
    logic i_ready = 1'b1;
    logic [lanes-1:0][bit_width-1:0] i_vec_a = '0;
    logic [lanes-1:0][bit_width-1:0] i_vec_b = '0;
    logic o_ready, o_valid, o_ready16, o_valid16;
    logic signed [acc_width-1:0]    o_dp;
    logic signed [narrow_width-1:0] o_dp16;

    always #5 clk = ~clk;

    dot_int_seq #(
        .bit_width (bit_width), .k (k), .lanes (lanes)
    ) dut (
        .i_clk (clk), .i_rst_n (rst_n), .i_valid (i_valid), .o_ready (o_ready),
        .i_vec_a (i_vec_a), .i_vec_b (i_vec_b), .o_valid (o_valid),
        .i_ready (i_ready), .o_dp (o_dp)
    );

    dot_int_seq #(
        .bit_width (bit_width), .k (k), .lanes (lanes), .out_width (narrow_width)
    ) dut16 (
        .i_clk (clk), .i_rst_n (rst_n), .i_valid (i_valid), .o_ready (o_ready16),
        .i_vec_a (i_vec_a), .i_vec_b (i_vec_b), .o_valid (o_valid16),
        .i_ready (i_ready), .o_dp (o_dp16)
    );

    // ---------------- model / scoreboard state ----------------
    logic signed [bit_width-1:0] va [k];
    logic signed [bit_width-1:0] vb [k];
    logic [acc_width-1:0]    exp_q[$];
    logic [narrow_width-1:0] exp16_q[$];
    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [narrow_width-1:0] narrow_of(input longint s);
        longint hi;
        longint lo;
        hi = (longint'(1) << (narrow_width - 1)) - 1;
        lo = -hi - 1;
`ifdef DOT_INT_SEQ_SAT_EN
        if (s > hi) return narrow_width'(hi);
        if (s < lo) return narrow_width'(lo);
`endif
        return s[narrow_width-1:0];
    endfunction

    task automatic push_expected();
        longint s;
        s = 0;
        for (int i = 0; i < k; i++) s += longint'(va[i]) * longint'(vb[i]);
        exp_q.push_back(s[acc_width-1:0]);
        exp16_q.push_back(narrow_of(s));
    endtask

    task automatic fill(input int a, input int b);
        for (int i = 0; i < k; i++) begin
            va[i] = bit_width'(a);
            vb[i] = bit_width'(b);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < k; i++) begin
            va[i] = bit_width'($urandom);
            vb[i] = bit_width'($urandom);
        end
    endtask

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic set_beat(input int beat);
        i_valid = 1'b1;
        for (int l = 0; l < lanes; l++) begin
            i_vec_a[l] = va[beat * lanes + l];
            i_vec_b[l] = vb[beat * lanes + l];
        end
    endtask

    task automatic drive_beat(input int beat);
        bit taken;
        taken = 1'b0;
        set_beat(beat);
        for (int t = 0; t < 200; t++) begin
            if (rand_ready) i_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (o_ready) begin
                taken = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        assert (taken) else begin
            errors++;
            $error("FAIL beat_accept: beat %0d o_ready=%b, required 1 within 200 cycles",
                   beat, o_ready);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_range(input int n_b, input int gap_max);
        for (int b = 0; b < n_b; b++) begin
            if (b > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drive_beat(b);
        end
    endtask

    task automatic wait_drain();
        rand_ready = 1'b0;
        i_ready    = 1'b1;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("drain_outstanding", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard: every result handshake ----------------
    always @(negedge clk) begin
        logic [acc_width-1:0]    want;
        logic [narrow_width-1:0] want16;
        if (rst_n && o_valid && i_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_result: got o_dp=%0d, required no result", o_dp);
            end
            if (exp_q.size() > 0) begin
                want   = exp_q.pop_front();
                want16 = exp16_q.pop_front();
                check("o_dp", o_dp, signed'(want));
                check("o_valid_narrow", o_valid16, 1);
                check("o_dp_narrow", o_dp16, signed'(want16));
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_valid", o_valid, 0);
        check("reset_o_dp", o_dp, 0);
        check("reset_o_ready", o_ready, 1);
        check("reset_o_dp_narrow", o_dp16, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_o_ready", o_ready, 1);

        // Ones vector: exact latency and single-cycle result.
        fill(1, 1);
        push_expected();
        send_range(n_beats, 0);
        @(negedge clk);
        check("lat_cycle1_valid", o_valid, 0);
        @(negedge clk);
        check("lat_cycle2_valid", o_valid, 1);
        check("lat_cycle2_dp", o_dp, 32);
        @(negedge clk);
        check("lat_cycle3_valid", o_valid, 0);
        @(posedge clk);
        #1;

        // Extreme operands, back to back.
        fill(-128, -128);
        push_expected();
        send_range(n_beats, 0);
        fill(-128, 127);
        push_expected();
        send_range(n_beats, 0);
        wait_drain();

        // Reset mid-vector discards the partial sum.
        fill(5, 7);
        send_range(2, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_o_valid", o_valid, 0);
        check("midreset_o_dp", o_dp, 0);
        check("midreset_o_ready", o_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill(2, 3);
        push_expected();
        send_range(n_beats, 0);
        wait_drain();

        // Output backpressure holds the pipe and the pending result.
        fill(1, 1);
        push_expected();
        i_ready = 1'b0;
        send_range(n_beats, 0);
        fill(0, 0);
        for (int b = 0; b < n_beats; b++) begin
            va[b * lanes] = 8'sd1;
            vb[b * lanes] = 8'sd1;
        end
        push_expected();
        drive_beat(0);
        set_beat(1);
        repeat (3) begin
            @(negedge clk);
            check("stall_o_ready", o_ready, 0);
            check("stall_o_valid", o_valid, 1);
            check("stall_o_dp", o_dp, 32);
            check("stall_o_dp_narrow", o_dp16, 32);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        for (int b = 1; b < n_beats; b++) drive_beat(b);
        wait_drain();

        // Same random vector without and with input gaps.
        fill_random();
        push_expected();
        send_range(n_beats, 0);
        push_expected();
        send_range(n_beats, 3);
        wait_drain();

        // Narrow output: saturate or wrap depending on build.
        fill(127, 127);
        push_expected();
        send_range(n_beats, 0);
        @(negedge clk);
        @(negedge clk);
        check("narrow_127_valid", o_valid16, 1);
        check("narrow_127_dp", o_dp16, narrow_127);
        check("wide_127_dp", o_dp, 516128);
        @(posedge clk);
        #1;
        wait_drain();

        // Random vectors with random gaps and random output backpressure.
        rand_ready = 1'b1;
        repeat (8) begin
            fill_random();
            push_expected();
            send_range(n_beats, $urandom_range(0, 2));
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
